ram2r1w_wr_sched: RTL and testbench

Write-port scheduler and initializer for the 2-read/1-write RAM used as register-file and tag storage. After reset, or on request, it sequences a full clear of every entry. It then shares the single write port between two requesters with round-robin arbitration. It also forwards same-address writes onto both synchronous read ports, so consumers never see stale data.

---
 rtl/ram2r1w_wr_sched.sv | 151 +++++++++++++++
 tb/tb_ram2r1w_wr_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram2r1w_wr_sched.sv
// ram2r1w_wr_sched: clear sequencer, round-robin write arbiter and read forwarding for a 2R1W RAM.
// Ports: clk/reset_n, clear_req/init_done, req0/req1 write handshakes, rd/ram read ports, ram write port.
module ram2r1w_wr_sched #(
  parameter int WIDTH = 64,
  parameter int LG_DEPTH = 6,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear_req,
  output logic                init_done,
  input  logic                req0_valid,
  input  logic [LG_DEPTH-1:0] req0_addr,
  input  logic [WIDTH-1:0]    req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [LG_DEPTH-1:0] req1_addr,
  input  logic [WIDTH-1:0]    req1_data,
  output logic                req1_ready,
  input  logic [LG_DEPTH-1:0] rd_addr0,
  input  logic [LG_DEPTH-1:0] rd_addr1,
  output logic [WIDTH-1:0]    rd_data0,
  output logic [WIDTH-1:0]    rd_data1,
  output logic                ram_wr_en,
  output logic [LG_DEPTH-1:0] ram_wr_addr,
  output logic [WIDTH-1:0]    ram_wr_data,
  output logic [LG_DEPTH-1:0] ram_rd_addr0,
  output logic [LG_DEPTH-1:0] ram_rd_addr1,
  input  logic [WIDTH-1:0]    ram_rd_data0,
  input  logic [WIDTH-1:0]    ram_rd_data1
);

  localparam int DEPTH = 2 ** LG_DEPTH;
  localparam logic [LG_DEPTH-1:0] LAST = LG_DEPTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t              state_q, state_d;
  logic [LG_DEPTH-1:0] clr_q, clr_d;
  logic                rr_q, rr_d;
  logic                g0, g1;
  logic                wr_en;
  logic [LG_DEPTH-1:0] wr_addr;
  logic [WIDTH-1:0]    wr_data;

  logic [LG_DEPTH-1:0] rd_a0_q, rd_a1_q;
  logic                fwd_en_q;
  logic [LG_DEPTH-1:0] fwd_addr_q;
  logic [WIDTH-1:0]    fwd_data_q;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    rr_d    = rr_q;
    g0      = 1'b0;
    g1      = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (state_q)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_q;
        wr_data = INIT_VALUE;
        clr_d   = clr_q + 1'b1;
        if (clear_req) clr_d = '0;
        else if (clr_q == LAST) state_d = RUN;
      end
      RUN: begin
        if (clear_req) begin
          state_d = CLEAR;
          clr_d   = '0;
        end else begin
          g0 = req0_valid & (~req1_valid | ~rr_q);
          g1 = req1_valid & (~req0_valid | rr_q);
          wr_en = g0 | g1;
          unique case (1'b1)
            g0: begin
              wr_addr = req0_addr;
              wr_data = req0_data;
              rr_d    = 1'b1;
            end
            g1: begin
              wr_addr = req1_addr;
              wr_data = req1_data;
              rr_d    = 1'b0;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      rr_q    <= rr_d;
    end
  end

  // The reset state is CLEAR, which would otherwise drive a write
  // while reset is still held.
  assign ram_wr_en   = reset_n & wr_en;
  assign ram_wr_addr = reset_n ? wr_addr : '0;
  assign ram_wr_data = reset_n ? wr_data : '0;

  assign init_done    = (state_q == RUN);
  assign req0_ready   = g0;
  assign req1_ready   = g1;
  assign ram_rd_addr0 = rd_addr0;
  assign ram_rd_addr1 = rd_addr1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_a0_q    <= '0;
      rd_a1_q    <= '0;
      fwd_en_q   <= 1'b0;
      fwd_addr_q <= '0;
      fwd_data_q <= '0;
    end else begin
      rd_a0_q    <= rd_addr0;
      rd_a1_q    <= rd_addr1;
      fwd_en_q   <= ram_wr_en;
      fwd_addr_q <= ram_wr_addr;
      fwd_data_q <= ram_wr_data;
    end
  end

  // The RAM returns pre-write data on a same-cycle collision.
  always_comb begin
    rd_data0 = ram_rd_data0;
    rd_data1 = ram_rd_data1;
    if (fwd_en_q && fwd_addr_q == rd_a0_q) rd_data0 = fwd_data_q;
    if (fwd_en_q && fwd_addr_q == rd_a1_q) rd_data1 = fwd_data_q;
    if (!reset_n) begin
      rd_data0 = '0;
      rd_data1 = '0;
    end
  end

endmodule

// File: tb/tb_ram2r1w_wr_sched.sv
// tb_ram2r1w_wr_sched: directed bench with behavioural RAM and read scoreboard.
// Covers clear, arbitration, forwarding, clear_req and async reset.
module tb_ram2r1w_wr_sched;
  localparam int W = 16;
  localparam int LG = 3;
  localparam logic [W-1:0] IV = 16'h00A5;

  logic clk = 1'b0;
  logic reset_n;
  logic clear_req;
  logic init_done;
  logic req0_valid, req1_valid;
  logic [LG-1:0] req0_addr, req1_addr;
  logic [W-1:0] req0_data, req1_data;
  logic req0_ready, req1_ready;
  logic [LG-1:0] rd_addr0, rd_addr1;
  logic [W-1:0] rd_data0, rd_data1;
  logic ram_wr_en;
  logic [LG-1:0] ram_wr_addr;
  logic [W-1:0] ram_wr_data;
  logic [LG-1:0] ram_rd_addr0, ram_rd_addr1;
  logic [W-1:0] ram_rd_data0, ram_rd_data1;

  int passes = 0;
  int fails = 0;
  int total = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [W-1:0] mem[8];

  always #5 clk = ~clk;

  ram2r1w_wr_sched #(
    .WIDTH(W),
    .LG_DEPTH(LG),
    .INIT_VALUE(IV)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clear_req(clear_req),
    .init_done(init_done),
    .req0_valid(req0_valid),
    .req0_addr(req0_addr),
    .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_addr(req1_addr),
    .req1_data(req1_data),
    .req1_ready(req1_ready),
    .rd_addr0(rd_addr0),
    .rd_addr1(rd_addr1),
    .rd_data0(rd_data0),
    .rd_data1(rd_data1),
    .ram_wr_en(ram_wr_en),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd_addr0(ram_rd_addr0),
    .ram_rd_addr1(ram_rd_addr1),
    .ram_rd_data0(ram_rd_data0),
    .ram_rd_data1(ram_rd_data1)
  );

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data0 <= mem[ram_rd_addr0];
    ram_rd_data1 <= mem[ram_rd_addr1];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (q0.size() > 0) chk("rd_data0", rd_data0, q0.pop_front());
    if (q1.size() > 0) chk("rd_data1", rd_data1, q1.pop_front());
  endtask

  task automatic rd(input logic [LG-1:0] a0, input logic [63:0] e0,
                    input logic [LG-1:0] a1, input logic [63:0] e1);
    rd_addr0 = a0;
    rd_addr1 = a1;
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic drv(input logic v0, input logic [LG-1:0] a0,
                     input logic [W-1:0] d0, input logic v1,
                     input logic [LG-1:0] a1, input logic [W-1:0] d1);
    req0_valid = v0;
    req0_addr  = a0;
    req0_data  = d0;
    req1_valid = v1;
    req1_addr  = a1;
    req1_data  = d1;
  endtask

  task automatic chk_grant(input string tag, input logic r0,
                           input logic r1, input logic [LG-1:0] a);
    chk({tag, ".ready0"}, req0_ready, r0);
    chk({tag, ".ready1"}, req1_ready, r1);
    chk({tag, ".wr_en"}, ram_wr_en, r0 | r1);
    if (r0 | r1) chk({tag, ".wr_addr"}, ram_wr_addr, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    clear_req = 1'b0;
    rd_addr0  = '0;
    rd_addr1  = '0;
    drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    #3;
    chk("rst.init_done", init_done, 1'b0);
    chk("rst.ready0", req0_ready, 1'b0);
    chk("rst.ready1", req1_ready, 1'b0);
    chk("rst.wr_en", ram_wr_en, 1'b0);
    chk("rst.wr_addr", ram_wr_addr, 0);
    chk("rst.wr_data", ram_wr_data, 0);
    chk("rst.rd_data0", rd_data0, 0);

    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drv(1'b1, 3'd1, 16'h1, 1'b1, 3'd2, 16'h2);
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("clr.wr_en", ram_wr_en, 1'b1);
      chk("clr.wr_addr", ram_wr_addr, i);
      chk("clr.wr_data", ram_wr_data, IV);
      chk("clr.ready0", req0_ready, 1'b0);
      chk("clr.ready1", req1_ready, 1'b0);
      chk("clr.init_done", init_done, 1'b0);
      cyc();
    end
    drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    #2;
    chk("clr.done", init_done, 1'b1);
    chk("clr.idle_wr_en", ram_wr_en, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rd(3'(i), IV, 3'(7 - i), IV);
      cyc();
    end

    drv(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk_grant("rr", (k % 2) == 0, (k % 2) == 1,
                (k % 2) == 0 ? 3'd1 : 3'd2);
      chk("rr.wr_data", ram_wr_data,
          (k % 2) == 0 ? 16'h1111 : 16'h2222);
      cyc();
    end

    drv(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h3333);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk_grant("single1", 1'b0, 1'b1, 3'd3);
      cyc();
    end
    drv(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222);
    #2;
    chk_grant("after_single", 1'b1, 1'b0, 3'd1);
    cyc();
    drv(1'b0, 3'd1, 16'h1111, 1'b0, 3'd2, 16'h2222);
    #2;
    chk_grant("idle", 1'b0, 1'b0, 3'd0);
    cyc();
    drv(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222);
    #2;
    chk_grant("after_idle", 1'b0, 1'b1, 3'd2);
    cyc();
    drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    rd(3'd1, 16'h1111, 3'd3, 16'h3333);
    cyc();
    rd(3'd2, 16'h2222, 3'd0, IV);
    cyc();

    drv(1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 16'h0);
    rd(3'd5, 16'h1234, 3'd5, 16'h1234);
    #2;
    chk_grant("fwd", 1'b1, 1'b0, 3'd5);
    cyc();
    drv(1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 16'h0);
    rd(3'd4, 16'h4444, 3'd6, IV);
    cyc();
    drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    rd(3'd6, IV, 3'd5, 16'h1234);
    cyc();
    rd(3'd4, 16'h4444, 3'd4, 16'h4444);
    cyc();

    clear_req = 1'b1;
    drv(1'b1, 3'd0, 16'hBEEF, 1'b0, 3'd0, 16'h0);
    #2;
    chk_grant("clrreq", 1'b0, 1'b0, 3'd0);
    cyc();
    clear_req = 1'b0;
    drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("reclr.wr_en", ram_wr_en, 1'b1);
      chk("reclr.wr_addr", ram_wr_addr, i);
      chk("reclr.init_done", init_done, 1'b0);
      cyc();
    end
    #2;
    chk("reclr.done", init_done, 1'b1);
    rd(3'd5, IV, 3'd1, IV);
    cyc();
    rd(3'd4, IV, 3'd0, IV);
    cyc();
    rd(3'd3, IV, 3'd2, IV);
    cyc();

    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    cyc();
    cyc();
    cyc();
    #2;
    chk("arst.pre_addr", ram_wr_addr, 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.wr_en", ram_wr_en, 1'b0);
    chk("arst.wr_addr", ram_wr_addr, 0);
    chk("arst.wr_data", ram_wr_data, 0);
    chk("arst.init_done", init_done, 1'b0);
    chk("arst.rd_data0", rd_data0, 0);
    chk("arst.rd_data1", rd_data1, 0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    chk("arst.rel_wr_en", ram_wr_en, 1'b1);
    chk("arst.rel_addr", ram_wr_addr, 0);
    cyc();
    #2;
    chk("arst.next_addr", ram_wr_addr, 1);
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    #2;
    chk("restart.addr", ram_wr_addr, 0);
    chk("restart.init_done", init_done, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
